// File: rtl/multiport_register_file.sv
// Register file with NREAD combinational read ports, two write ports and a
// per-register busy (reservation) bit for scoreboard-style hazard tracking.
module multiport_register_file #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   read_address,
  output logic [NREAD*XLEN-1:0] read_data,
  output logic [NREAD-1:0]      read_busy,
  input  logic [1:0]            write_enable,
  input  logic [2*AW-1:0]       write_address,
  input  logic [2*XLEN-1:0]     write_data,
  input  logic                  reserve_enable,
  input  logic [AW-1:0]         reserve_address
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic [AW-1:0]   wa0, wa1;
  logic [XLEN-1:0] wd0, wd1;
  logic [1:0]      we_eff;
  logic            rsv_eff;

  assign wa0 = write_address[0 +: AW];
  assign wa1 = write_address[AW +: AW];
  assign wd0 = write_data[0 +: XLEN];
  assign wd1 = write_data[XLEN +: XLEN];

  // With a hardwired zero register, anything aimed at r0 is dropped here so
  // neither storage, busy tracking nor bypass ever sees it.
  assign we_eff[0] = write_enable[0] & ~((ZERO_REG != 0) && (wa0 == '0));
  assign we_eff[1] = write_enable[1] & ~((ZERO_REG != 0) && (wa1 == '0));
  assign rsv_eff   = reserve_enable & ~((ZERO_REG != 0) && (reserve_address == '0));

  // Port 1 is applied after port 0 so it wins a same-address collision; the
  // reserve is applied last so a new producer outranks a completing write.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      mem_d[r] = mem_q[r];
    end
    busy_d = busy_q;
    if (we_eff[0]) begin
      mem_d[wa0]  = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (we_eff[1]) begin
      mem_d[wa1]  = wd1;
      busy_d[wa1] = 1'b0;
    end
    if (rsv_eff) begin
      busy_d[reserve_address] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign ra = read_address[i*AW +: AW];

    // A same-cycle write hides the reservation it retires, unless a new
    // reservation of the same register lands at the same edge.
    always_comb begin
      rd = mem_q[ra];
      rb = busy_q[ra];
      if (BYPASS != 0) begin
        if (we_eff[0] && (wa0 == ra)) begin
          rd = wd0;
          rb = 1'b0;
        end
        if (we_eff[1] && (wa1 == ra)) begin
          rd = wd1;
          rb = 1'b0;
        end
        if (rsv_eff && (reserve_address == ra)) begin
          rb = busy_q[ra];
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign read_data[i*XLEN +: XLEN] = rd;
    assign read_busy[i]              = rb;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file at default parameters: reset,
// dual writes, collisions, zero register, reservations and mid-run reset.
module tb_multiport_register_file;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk;
  logic                  reset;
  logic [NREAD*AW-1:0]   read_address;
  logic [NREAD*XLEN-1:0] read_data;
  logic [NREAD-1:0]      read_busy;
  logic [1:0]            write_enable;
  logic [2*AW-1:0]       write_address;
  logic [2*XLEN-1:0]     write_data;
  logic                  reserve_enable;
  logic [AW-1:0]         reserve_address;

  int n_checks;
  int n_fail;
  logic [XLEN-1:0] exp_q[$];

  multiport_register_file dut (
    .clk             (clk),
    .reset           (reset),
    .read_address    (read_address),
    .read_data       (read_data),
    .read_busy       (read_busy),
    .write_enable    (write_enable),
    .write_address   (write_address),
    .write_data      (write_data),
    .reserve_enable  (reserve_enable),
    .reserve_address (reserve_address)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable    = 2'b00;
    write_address   = '0;
    write_data      = '0;
    reserve_enable  = 1'b0;
    reserve_address = '0;
  endtask

  task automatic set_rd(input int port, input logic [AW-1:0] a);
    read_address[port*AW +: AW] = a;
  endtask

  task automatic drive_wr(input int port, input logic [AW-1:0] a,
                          input logic [XLEN-1:0] d);
    write_enable[port]             = 1'b1;
    write_address[port*AW +: AW]   = a;
    write_data[port*XLEN +: XLEN]  = d;
  endtask

  task automatic drive_rsv(input logic [AW-1:0] a);
    reserve_enable  = 1'b1;
    reserve_address = a;
  endtask

  function automatic logic [XLEN-1:0] rdat(input int port);
    return read_data[port*XLEN +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] rbsy(input int port);
    return {{(XLEN-1){1'b0}}, read_busy[port]};
  endfunction

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    read_address = '0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // After reset every address reads zero and not busy on both ports
    for (int a = 0; a < NREGS; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(a));
      #2;
      check($sformatf("rst_data_p0_r%0d", a), rdat(0), 0);
      check($sformatf("rst_data_p1_r%0d", a), rdat(1), 0);
      check($sformatf("rst_busy_p0_r%0d", a), rbsy(0), 0);
      check($sformatf("rst_busy_p1_r%0d", a), rbsy(1), 0);
      tick();
    end

    // Dual write, then crossed reads
    drive_wr(0, 5'd1, 32'd1234);
    drive_wr(1, 5'd2, 32'd5678);
    tick();
    idle();
    set_rd(0, 5'd2);
    set_rd(1, 5'd1);
    exp_q.push_back(32'd5678);
    exp_q.push_back(32'd1234);
    #1;
    check("dual_wr_p0", rdat(0), exp_q.pop_front());
    check("dual_wr_p1", rdat(1), exp_q.pop_front());

    // Same-address collision: port 1 wins for bypass and storage
    drive_wr(0, 5'd5, 32'h0000_AAAA);
    drive_wr(1, 5'd5, 32'h0000_5555);
    set_rd(0, 5'd5);
    set_rd(1, 5'd5);
    #1;
    check("collide_bypass", rdat(0), 32'h0000_5555);
    tick();
    idle();
    #1;
    check("collide_stored", rdat(0), 32'h0000_5555);
    tick();
    check("collide_stored2", rdat(1), 32'h0000_5555);

    // Zero register ignores writes and reserves
    drive_wr(0, 5'd0, 32'hFFFF_FFFF);
    drive_rsv(5'd0);
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    #1;
    check("r0_bypass_data", rdat(0), 0);
    check("r0_bypass_busy", rbsy(0), 0);
    tick();
    idle();
    #1;
    check("r0_data", rdat(1), 0);
    check("r0_busy", rbsy(1), 0);

    // Reservation lifecycle on r7
    drive_rsv(5'd7);
    tick();
    idle();
    set_rd(0, 5'd7);
    set_rd(1, 5'd7);
    #1;
    check("r7_busy_after_rsv", rbsy(0), 1);
    check("r7_data_before_wr", rdat(1), 0);
    drive_wr(0, 5'd7, 32'd42);
    #1;
    check("r7_bypass_data", rdat(0), 32'd42);
    check("r7_bypass_busy", rbsy(1), 0);
    tick();
    idle();
    #1;
    check("r7_busy_cleared", rbsy(0), 0);
    check("r7_data_stored", rdat(0), 32'd42);
    drive_wr(1, 5'd7, 32'd42);
    drive_rsv(5'd7);
    #1;
    check("r7_rsv_wr_same_busy", rbsy(0), 0);
    check("r7_rsv_wr_same_data", rdat(1), 32'd42);
    tick();
    idle();
    #1;
    check("r7_rsv_wr_busy", rbsy(0), 1);
    check("r7_rsv_wr_data", rdat(1), 32'd42);

    // Double reserve does not count; one write clears; non-busy write legal
    drive_rsv(5'd8);
    tick();
    drive_rsv(5'd8);
    tick();
    idle();
    set_rd(0, 5'd8);
    set_rd(1, 5'd9);
    #1;
    check("r8_busy_double", rbsy(0), 1);
    drive_wr(1, 5'd8, 32'hDEAD_BEEF);
    drive_wr(0, 5'd9, 32'h0BAD_F00D);
    tick();
    idle();
    #1;
    check("r8_busy_one_wr", rbsy(0), 0);
    check("r8_data", rdat(0), 32'hDEAD_BEEF);
    check("r9_data", rdat(1), 32'h0BAD_F00D);
    check("r9_busy", rbsy(1), 0);

    // Reset mid-sequence discards everything, including that cycle's traffic
    drive_wr(0, 5'd3, 32'd99);
    drive_rsv(5'd4);
    tick();
    idle();
    set_rd(0, 5'd3);
    set_rd(1, 5'd4);
    #1;
    check("r3_before_rst", rdat(0), 32'd99);
    check("r4_busy_before_rst", rbsy(1), 1);
    reset = 1'b1;
    drive_wr(0, 5'd3, 32'd77);
    drive_wr(1, 5'd10, 32'd55);
    drive_rsv(5'd11);
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("r3_after_rst", rdat(0), 0);
    check("r4_busy_after_rst", rbsy(1), 0);
    set_rd(0, 5'd10);
    set_rd(1, 5'd11);
    #1;
    check("r10_after_rst", rdat(0), 0);
    check("r11_busy_after_rst", rbsy(1), 0);
    set_rd(0, 5'd5);
    set_rd(1, 5'd7);
    #1;
    check("r5_after_rst", rdat(0), 0);
    check("r7_busy_after_rst", rbsy(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
